// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and runs single-outstanding imem fetches into a decode holding register.
module pc_fetch_sequencer #(
  parameter int WIDTH = 32,
  parameter int INSTR_W = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic               instr_ready,
  output logic [WIDTH-1:0]   pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic squash_q, squash_d, fire;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = en ? REQ : IDLE;
      REQ:  state_d = imem_gnt ? WAIT : (en ? REQ : IDLE);
      WAIT: state_d = !imem_rvalid ? WAIT : (squash_q || redirect) ? (en ? REQ : IDLE) : HOLD;
      HOLD: state_d = (instr_ready || redirect) ? (en ? REQ : IDLE) : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // a response only lands when the granted address is still the one we want
  always_comb begin
    fire       = state_q == WAIT && imem_rvalid && !squash_q && !redirect;
    pc_d       = redirect ? (redirect_pc & ~WIDTH'(3)) : fire ? pc_q + WIDTH'(4) : pc_q;
    squash_d   = state_q == REQ ? (imem_gnt && redirect) :
                 state_q == WAIT ? (!imem_rvalid && (squash_q || redirect)) : 1'b0;
    instr_d    = fire ? imem_rdata : instr_q;
    instr_pc_d = fire ? pc_q : instr_pc_q;
  end
  always_comb begin
    imem_req    = state_q == REQ;
    instr_valid = state_q == HOLD;
  end
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed checks of the fetch sequencer against a one-cycle-latency memory model.
module tb_pc_fetch_sequencer;
  logic clk = 0, rst = 0, en = 0, redirect = 0, instr_ready = 1;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_gnt, imem_rvalid, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc;
  logic pend = 0, gnt_block = 0, rv_block = 0;
  logic [31:0] addr_q = '0;
  int checks = 0, errors = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  // memory: grants immediately, answers the cycle after grant unless held back
  assign imem_gnt    = imem_req && !gnt_block;
  assign imem_rvalid = pend && !rv_block;
  assign imem_rdata  = addr_q ^ 32'hA500_0000;
  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      pend   <= 1'b1;
      addr_q <= imem_addr;
    end else if (imem_rvalid) pend <= 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #1 rst = 1;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst = 0; en = 1;
    step();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", instr_valid, 0);
    step();
    chk("c2_req", imem_req, 0);
    chk("c2_valid", instr_valid, 0);
    step();
    chk("c3_valid", instr_valid, 1);
    chk("c3_instr_pc", instr_pc, 32'h0);
    chk("c3_instr", instr, 32'hA500_0000);
    chk("c3_pc", pc, 32'h4);
    step();
    chk("c4_valid", instr_valid, 0);
    chk("c4_addr", imem_addr, 32'h4);
    step();
    step();
    chk("c6_valid", instr_valid, 1);
    chk("c6_instr_pc", instr_pc, 32'h4);
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, 32'hA500_0004);
      chk("stall_instr_pc", instr_pc, 32'h4);
      chk("stall_pc", pc, 32'h8);
      chk("stall_req", imem_req, 0);
    end
    instr_ready = 1;
    step(); step(); step();
    chk("c3rd_valid", instr_valid, 1);
    chk("c3rd_instr_pc", instr_pc, 32'h8);
    chk("c3rd_instr", instr, 32'hA500_0008);
    // redirect while waiting for the response
    rv_block = 1;
    step();
    chk("rw_addr", imem_addr, 32'hC);
    step();
    redirect = 1; redirect_pc = 32'h103;
    step();
    chk("rw_pc", pc, 32'h100);
    chk("rw_req", imem_req, 0);
    redirect = 0; rv_block = 0;
    step();
    chk("rw_drop_valid", instr_valid, 0);
    chk("rw_req2", imem_req, 1);
    chk("rw_addr2", imem_addr, 32'h100);
    step(); step();
    chk("rw_valid", instr_valid, 1);
    chk("rw_instr_pc", instr_pc, 32'h100);
    chk("rw_instr", instr, 32'hA500_0100);
    chk("rw_next_pc", pc, 32'h104);
    // redirect in the same cycle as grant
    step();
    chk("rg_addr", imem_addr, 32'h104);
    redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    chk("rg_pc", pc, 32'h40);
    step();
    chk("rg_drop_valid", instr_valid, 0);
    chk("rg_req", imem_req, 1);
    chk("rg_addr2", imem_addr, 32'h40);
    step(); step();
    chk("rg_instr_pc", instr_pc, 32'h40);
    chk("rg_instr", instr, 32'hA500_0040);
    // redirect out of HOLD towards the top of the address space
    redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 0;
    chk("wr_valid", instr_valid, 0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(); step();
    chk("wr_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, 32'h5AFF_FFFC);
    chk("wr_pc", pc, 32'h0);
    step();
    chk("wr_addr2", imem_addr, 32'h0);
    // en drops while a response is outstanding
    step();
    en = 0;
    step();
    chk("en_valid", instr_valid, 1);
    chk("en_instr_pc", instr_pc, 32'h0);
    chk("en_pc", pc, 32'h4);
    step();
    chk("en_idle_req", imem_req, 0);
    chk("en_idle_valid", instr_valid, 0);
    step();
    chk("en_idle_req2", imem_req, 0);
    // reset during WAIT with the response arriving afterwards
    en = 1; rv_block = 1;
    step();
    chk("rs_addr", imem_addr, 32'h4);
    step();
    rst = 1;
    #1;
    chk("rs_pc", pc, 32'h0);
    chk("rs_valid", instr_valid, 0);
    chk("rs_req", imem_req, 0);
    step();
    rst = 0; en = 0; rv_block = 0;
    step();
    chk("late_valid", instr_valid, 0);
    chk("late_req", imem_req, 0);
    chk("late_pc", pc, 32'h0);
    chk("late_instr_pc", instr_pc, 32'h0);
    en = 1;
    step();
    chk("post_addr", imem_addr, 32'h0);
    step(); step();
    chk("post_valid", instr_valid, 1);
    chk("post_instr", instr, 32'hA500_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-side controller for the reduced RISC-V core. It owns the program counter and sequences instruction-memory fetches through a single-outstanding request/grant/response handshake. It handles branch/jump redirects, including squashing in-flight fetches, and presents fetched instructions to decode with a valid/ready handshake.

Parameters:
WIDTH, 32, PC / instruction-memory address width in bits (minimum 3)
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; while low, no new fetch is issued
redirect  input  1  taken branch/jump this cycle
redirect_pc  input  WIDTH  redirect target; bits [1:0] ignored and treated as 0
imem_req  output  1  fetch request valid
imem_addr  output  WIDTH  fetch address; always equals pc
imem_gnt  input  1  memory accepts the request this cycle
imem_rvalid  input  1  fetch response valid
imem_rdata  input  INSTR_W  fetch response data
instr_valid  output  1  instruction held for decode
instr  output  INSTR_W  held instruction
instr_pc  output  WIDTH  address of the held instruction
instr_ready  input  1  decode consumes the instruction
pc  output  WIDTH  current fetch PC

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, squash=0, instr_valid=0, instr=0, instr_pc=0, imem_req=0. Reset mid-transaction abandons it; any later imem_rvalid is ignored until the next grant.
- imem_req = (state==REQ). imem_addr = pc (combinational).
- Redirect, all states:
  - pc <= {redirect_pc[WIDTH-1:2],2'b00}.
  - Redirect has priority over the sequential pc+4 update.
  - Only one redirect target per cycle.
- Sequential update: pc <= pc+4, modulo 2^WIDTH. Wrap from all-ones-aligned to 0 is silent.
- States:
  - IDLE:
    - en=1 -> REQ.
    - Otherwise stay.
  - REQ:
    - en=0 and no gnt -> IDLE. The request is withdrawn; this is legal before grant.
    - gnt=1 -> WAIT. If redirect is high in the same cycle, squash<=1 because the granted address is stale.
    - Redirect without gnt: stay REQ. imem_addr shows the new pc next cycle.
  - WAIT:
    - Redirect without rvalid: squash<=1, stay WAIT.
    - rvalid with (squash or redirect): drop the data, squash<=0, then -> REQ if en, else -> IDLE.
    - rvalid otherwise: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
    - en low does not abort WAIT; the outstanding response is always drained.
  - HOLD:
    - instr_valid=1; instr and instr_pc are stable until consumed.
    - instr_ready=1: instr_valid<=0, then -> REQ if en, else -> IDLE.
    - Redirect, with or without ready: instr_valid<=0 (the held instruction is dropped), then -> REQ if en, else -> IDLE.
- imem_rvalid outside WAIT is ignored. imem_gnt outside REQ is ignored.
- Latency:
  - Grant in cycle n -> earliest rvalid n+1 -> instr_valid high in n+2.
  - With a zero-wait memory and instr_ready always high: one instruction per 3 cycles (REQ, WAIT, HOLD).
- At most one outstanding fetch at any time.

Test Plan:
- Reset, en=1, memory with gnt=1 and rvalid one cycle after grant, ready=1 -> instr_pc sequence 0x0,0x4,0x8; instr_valid pulses every 3rd cycle; first instr_valid in cycle 3 after reset release.
- In HOLD with instr_ready=0 for 5 cycles -> instr and instr_pc stable; pc stays at instr_pc+4; no imem_req issued.
- Redirect to 0x103 in WAIT before rvalid -> returned data is dropped (instr_valid stays 0); next imem_addr=0x100; following instr_pc=0x100.
- Redirect to 0x40 in the same cycle as gnt in REQ -> the response is squashed; the next request is to 0x40.
- pc=0xFFFFFFFC fetch completes -> instr_pc=0xFFFFFFFC, next imem_addr=0x0.
- en dropped during WAIT -> response is delivered normally, then IDLE with no imem_req. Assert rst during WAIT, then release -> pc=RESET_PC, instr_valid=0, and a late rvalid is ignored.
